nios_system_main_memory_arbiter: RTL and testbench
==================================================

NIOS_SYSTEM_MAIN_MEMORY_ARBITER -- requirements
Module: nios_system_main_memory_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 25600, number of implemented 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 15, word-address width.
REQ-003 SHALL have ports clk (in, 1, sole clock) and reset (in, 1); one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports m0_address/m1_address (in, ADDR_W, word address) and m0_byteenable/m1_byteenable (in, 4, byte lanes).
REQ-005 SHALL have ports m0_read/m1_read (in, 1, read request), m0_write/m1_write (in, 1, write request) and m0_lock/m1_lock (in, 1, hold grant).
REQ-006 SHALL have ports m0_writedata/m1_writedata (in, 32), m0_waitrequest/m1_waitrequest (out, 1), m0_readdata/m1_readdata (out, 32) and m0_readdatavalid/m1_readdatavalid (out, 1).
REQ-007 SHALL have memory-side ports mem_address (out, ADDR_W), mem_byteenable (out, 4), mem_chipselect (out, 1), mem_write (out, 1), mem_writedata (out, 32), mem_clken (out, 1) and mem_readdata (in, 32, unregistered RAM output).
REQ-008 SHALL have port range_err (out, 1), a sticky out-of-range or protocol error flag.

Function
REQ-009 Request from master n SHALL be defined as mn_read OR mn_write.
REQ-010 At most one master SHALL be granted per cycle; grant is combinational from current requests and state.
REQ-011 Granted master: waitrequest low. Any other requesting master: waitrequest high. Non-requesting master: waitrequest high.
REQ-012 If only one master requests, it SHALL win; if both request in IDLE, the master not granted most recently SHALL win (round-robin).
REQ-013 A granted transfer SHALL drive mem_chipselect=1, with mem_address, mem_byteenable and mem_writedata taken from the winner, in the same cycle.
REQ-014 mem_write SHALL equal the winner's write; mem_chipselect SHALL be 0 when there is no grant.
REQ-015 mem_clken SHALL be 1 whenever reset is low.
REQ-016 Read latency SHALL be exactly 1 cycle: the cycle after a granted read, the winner's readdatavalid=1 and its readdata=mem_readdata.
REQ-017 readdatavalid SHALL be 1 for exactly one cycle per granted read and never for writes.
REQ-018 Back-to-back granted reads, including alternating masters, SHALL sustain one transfer per cycle.
REQ-019 Address >= DEPTH: write SHALL be suppressed (mem_chipselect=0), read SHALL still complete with readdata=0 after 1 cycle, and range_err SHALL be set.
REQ-020 A master asserting read and write together SHALL be treated as a write, and range_err SHALL be set.
REQ-021 FSM states:
- IDLE: round-robin arbitration.
- LOCKED_M0 / LOCKED_M1: only the locked master may be granted.
REQ-022 IDLE->LOCKED_Mn SHALL occur when master n is granted with mn_lock=1.
REQ-023 LOCKED_Mn->IDLE SHALL occur when master n is granted with mn_lock=0, or when mn_lock=0 with no request from n.
REQ-024 While LOCKED_Mn, the other master's waitrequest SHALL stay high even if n is idle with lock high.
REQ-025 range_err SHALL be cleared only by reset.

Reset
REQ-026 During reset: state=IDLE, last-grant=M1 (so M0 wins the first contention), readdatavalid=0, readdata=0, range_err=0, mem_chipselect=0, mem_clken=0, both waitrequest=1.
REQ-027 A read granted in the cycle before reset asserts SHALL produce no readdatavalid after reset.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE, LOCKED_M0, LOCKED_M1), DEPTH default, and the read-latency constant (1).
REQ-029 One sub-module, nios_system_main_memory_rr_arbiter (2-way round-robin grant with lock), is natural; the datapath mux and read-return pipeline stay in the top.

Verification
REQ-030 m0 reads addr 0x0010 while m1 idle -> m0_waitrequest=0 same cycle; m0_readdatavalid=1 next cycle with RAM word 0x0010.
REQ-031 Both masters write every cycle after reset -> grants alternate M0,M1,M0,...; each write lands at its own address with correct byte lanes.
REQ-032 m1 writes 0x1234 with lock=1, then reads 0x1234 with lock=0, while m0 requests throughout -> m0_waitrequest stays high for both cycles; m0 granted the cycle after.
REQ-033 m0 writes addr 25600 -> mem_chipselect=0 and range_err=1; m0 reads 25601 -> readdatavalid next cycle with readdata=0x00000000.
REQ-034 Reset asserted the cycle after a granted m1 read -> m1_readdatavalid never pulses; all outputs at reset values.
REQ-035 Alternating m0/m1 reads of 0x0001 and 0x0002 every cycle -> readdatavalid pulses route to the correct master with no bubbles.

Source files
------------

// File: rtl/nios_system_main_memory_arbiter_pkg.sv
// Shared types and constants for the two-master main-memory arbiter.
package nios_system_main_memory_arbiter_pkg;

    localparam int unsigned DEPTH_DEFAULT = 25600;
    localparam int unsigned RD_LATENCY    = 1;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BE_W          = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCKED_M0 = 2'd1,
        ST_LOCKED_M1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } mst_cmd_t;

    typedef struct packed {
        logic v0;
        logic v1;
        logic zero;
    } rd_tag_t;

    // Read together with write is demoted to a plain write.
    function automatic mst_cmd_t normalize_cmd(
        input logic              rd,
        input logic              wr,
        input logic [BE_W-1:0]   be,
        input logic [DATA_W-1:0] wdata
    );
        mst_cmd_t c;
        c.rd    = rd & ~wr;
        c.wr    = wr;
        c.be    = be;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/nios_system_main_memory_rr_arbiter.sv
// Two-way round-robin grant with per-master lock; grant is combinational
// from the current requests, the lock state and the last winner.
module nios_system_main_memory_rr_arbiter
    import nios_system_main_memory_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic lock0_i,
    input  logic lock1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    arb_state_e state_q, state_d;
    master_e    last_q, last_d;

    // State register; last winner starts at M1 so M0 takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= MST_M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Grant decode.
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_LOCKED_M0: gnt0_o = req0_i;
                ST_LOCKED_M1: gnt1_o = req1_i;
                default: begin
                    if (req0_i && req1_i) begin
                        gnt0_o = (last_q == MST_M1);
                        gnt1_o = (last_q == MST_M0);
                    end else begin
                        gnt0_o = req0_i;
                        gnt1_o = req1_i;
                    end
                end
            endcase
        end
    end

    // Next state and last-winner tracking.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (gnt0_o) begin
            last_d = MST_M0;
        end else if (gnt1_o) begin
            last_d = MST_M1;
        end
        unique case (state_q)
            ST_LOCKED_M0: begin
                if (!lock0_i && (gnt0_o || !req0_i)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED_M1: begin
                if (!lock1_i && (gnt1_o || !req1_i)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (gnt0_o && lock0_i) begin
                    state_d = ST_LOCKED_M0;
                end else if (gnt1_o && lock1_i) begin
                    state_d = ST_LOCKED_M1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

endmodule

// File: rtl/nios_system_main_memory_arbiter.sv
// Two Avalon-MM masters sharing one on-chip RAM: arbitration, winner mux,
// range/protocol checking and the 1-cycle read-return path.
module nios_system_main_memory_arbiter
    import nios_system_main_memory_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic              m0_lock,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic              m1_lock,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              range_err
);

    mst_cmd_t          m0_cmd, m1_cmd, sel_cmd;
    logic              m0_oor, m1_oor, sel_oor, sel_proto;
    logic [ADDR_W-1:0] sel_addr;
    logic              gnt0, gnt1, gnt_any;
    rd_tag_t           rd_tag_d, rd_out;
    rd_tag_t           rd_pipe_q [RD_LATENCY];
    logic              range_err_q, range_err_d;

    assign m0_cmd = normalize_cmd(m0_read, m0_write, m0_byteenable, m0_writedata);
    assign m1_cmd = normalize_cmd(m1_read, m1_write, m1_byteenable, m1_writedata);
    assign m0_oor = (32'(m0_address) >= 32'(DEPTH));
    assign m1_oor = (32'(m1_address) >= 32'(DEPTH));

    nios_system_main_memory_rr_arbiter u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req0_i  (m0_read | m0_write),
        .req1_i  (m1_read | m1_write),
        .lock0_i (m0_lock),
        .lock1_i (m1_lock),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1)
    );

    assign gnt_any        = gnt0 | gnt1;
    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    // Winner mux; all zeros when nobody is granted.
    always_comb begin
        sel_cmd   = '0;
        sel_addr  = '0;
        sel_oor   = 1'b0;
        sel_proto = 1'b0;
        if (gnt0) begin
            sel_cmd   = m0_cmd;
            sel_addr  = m0_address;
            sel_oor   = m0_oor;
            sel_proto = m0_read & m0_write;
        end else if (gnt1) begin
            sel_cmd   = m1_cmd;
            sel_addr  = m1_address;
            sel_oor   = m1_oor;
            sel_proto = m1_read & m1_write;
        end
    end

    // Out-of-range accesses never reach the RAM; reads return zero instead.
    assign mem_chipselect = gnt_any & ~sel_oor;
    assign mem_write      = sel_cmd.wr;
    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_cmd.be;
    assign mem_writedata  = sel_cmd.wdata;
    assign mem_clken      = ~reset;

    always_comb begin
        rd_tag_d      = '0;
        rd_tag_d.v0   = gnt0 & m0_cmd.rd;
        rd_tag_d.v1   = gnt1 & m1_cmd.rd;
        rd_tag_d.zero = sel_oor;
        range_err_d   = range_err_q | (gnt_any & (sel_oor | sel_proto));
    end

    // Read-return tag pipeline, one stage per cycle of RAM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                rd_pipe_q[i] <= '0;
            end
            range_err_q <= 1'b0;
        end else begin
            rd_pipe_q[0] <= rd_tag_d;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
            range_err_q <= range_err_d;
        end
    end

    assign rd_out           = rd_pipe_q[RD_LATENCY-1];
    assign m0_readdatavalid = rd_out.v0;
    assign m1_readdatavalid = rd_out.v1;
    assign m0_readdata      = (rd_out.v0 && !rd_out.zero) ? mem_readdata : '0;
    assign m1_readdata      = (rd_out.v1 && !rd_out.zero) ? mem_readdata : '0;
    assign range_err        = range_err_q;

endmodule

// File: tb/tb_nios_system_main_memory_arbiter.sv
// Directed self-checking bench for the main-memory arbiter with a 1-cycle
// synchronous RAM model behind the memory port.
module tb_nios_system_main_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        range_err;

    logic [31:0] ram [32768];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    nios_system_main_memory_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_lock          (m0_lock),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_lock          (m1_lock),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .range_err        (range_err)
    );

    // RAM model: word a initialises to 0xA500_0000 | a, read data one cycle later.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 32'hA500_0000 | 32'(i);
            mem_readdata <= 32'h0;
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic drive_idle();
        m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_lock = 0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_lock = 0; m1_writedata = '0;
    endtask

    task automatic settle(); #2; endtask
    task automatic next();   @(posedge clk); #1; endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr0"}, 32'(m0_waitrequest), 32'd1);
        check({tag, "_wr1"}, 32'(m1_waitrequest), 32'd1);
        check({tag, "_cs"},  32'(mem_chipselect), 32'd0);
        check({tag, "_clk"}, 32'(mem_clken), 32'd0);
        check({tag, "_rv0"}, 32'(m0_readdatavalid), 32'd0);
        check({tag, "_rv1"}, 32'(m1_readdatavalid), 32'd0);
        check({tag, "_rd0"}, m0_readdata, 32'h0);
        check({tag, "_rd1"}, m1_readdata, 32'h0);
        check({tag, "_err"}, 32'(range_err), 32'd0);
    endtask

    // Write-alternation vectors: per cycle which command each master drives.
    logic [14:0] w0_addr [2] = '{15'h20, 15'h21};
    logic [3:0]  w0_be   [2] = '{4'b0001, 4'b0110};
    logic [31:0] w0_data [2] = '{32'h1111_1111, 32'h3333_3333};
    logic [14:0] w1_addr [2] = '{15'h30, 15'h31};
    logic [3:0]  w1_be   [2] = '{4'b1100, 4'b1111};
    logic [31:0] w1_data [2] = '{32'h2222_2222, 32'h4444_4444};
    int          m0_sel  [4] = '{0, 1, 1, 1};
    int          m1_sel  [4] = '{0, 0, 1, 1};
    logic        exp_m1  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [14:0] exp_addr[4] = '{15'h20, 15'h30, 15'h21, 15'h31};
    logic [3:0]  exp_be  [4] = '{4'b0001, 4'b1100, 4'b0110, 4'b1111};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        drive_idle();
        m0_read = 1; m1_write = 1;
        #3;
        check_reset_values("rst");
        do_reset();

        // Single read from m0.
        m0_read = 1; m0_address = 15'h0010; m0_byteenable = 4'hF;
        settle();
        check("t030_wr0", 32'(m0_waitrequest), 32'd0);
        check("t030_wr1", 32'(m1_waitrequest), 32'd1);
        check("t030_cs",  32'(mem_chipselect), 32'd1);
        check("t030_adr", 32'(mem_address), 32'h10);
        check("t030_we",  32'(mem_write), 32'd0);
        check("t030_clk", 32'(mem_clken), 32'd1);
        next(); drive_idle(); settle();
        check("t030_rv0", 32'(m0_readdatavalid), 32'd1);
        check("t030_rd0", m0_readdata, 32'hA500_0010);
        check("t030_rv1", 32'(m1_readdatavalid), 32'd0);
        next(); settle();
        check("t030_rv0_off", 32'(m0_readdatavalid), 32'd0);
        next();

        // Locked m1 write then read while m0 keeps requesting.
        m0_read = 1; m0_address = 15'h0005; m0_byteenable = 4'hF;
        m1_write = 1; m1_lock = 1; m1_address = 15'h1234; m1_byteenable = 4'hF; m1_writedata = 32'hCAFE_F00D;
        settle();
        check("t032a_wr0", 32'(m0_waitrequest), 32'd1);
        check("t032a_wr1", 32'(m1_waitrequest), 32'd0);
        check("t032a_adr", 32'(mem_address), 32'h1234);
        check("t032a_we",  32'(mem_write), 32'd1);
        next();
        m1_write = 0; m1_read = 1; m1_lock = 0;
        settle();
        check("t032b_wr0", 32'(m0_waitrequest), 32'd1);
        check("t032b_wr1", 32'(m1_waitrequest), 32'd0);
        next();
        m1_read = 0;
        settle();
        check("t032c_wr0", 32'(m0_waitrequest), 32'd0);
        check("t032c_rv1", 32'(m1_readdatavalid), 32'd1);
        check("t032c_rd1", m1_readdata, 32'hCAFE_F00D);
        next();
        m0_read = 0;
        settle();
        check("t032d_rv0", 32'(m0_readdatavalid), 32'd1);
        check("t032d_rd0", m0_readdata, 32'hA500_0005);
        check("t032d_rv1", 32'(m1_readdatavalid), 32'd0);
        next();

        // Lock held by an idle m1 still blocks m0.
        m0_read = 1;
        m1_write = 1; m1_lock = 1; m1_address = 15'h1235; m1_writedata = 32'h5555_AAAA;
        settle();
        check("t024a_wr1", 32'(m1_waitrequest), 32'd0);
        next();
        m1_write = 0;
        settle();
        check("t024b_wr0", 32'(m0_waitrequest), 32'd1);
        next();
        m1_lock = 0;
        settle();
        check("t024c_wr0", 32'(m0_waitrequest), 32'd1);
        next(); settle();
        check("t024d_wr0", 32'(m0_waitrequest), 32'd0);
        next(); drive_idle();

        // Both masters write every cycle: grants alternate starting with m0.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            m0_write = 1; m0_address = w0_addr[m0_sel[c]]; m0_byteenable = w0_be[m0_sel[c]]; m0_writedata = w0_data[m0_sel[c]];
            m1_write = 1; m1_address = w1_addr[m1_sel[c]]; m1_byteenable = w1_be[m1_sel[c]]; m1_writedata = w1_data[m1_sel[c]];
            settle();
            check($sformatf("t031_wr0_%0d", c), 32'(m0_waitrequest), 32'(exp_m1[c]));
            check($sformatf("t031_wr1_%0d", c), 32'(m1_waitrequest), 32'(!exp_m1[c]));
            check($sformatf("t031_adr_%0d", c), 32'(mem_address), 32'(exp_addr[c]));
            check($sformatf("t031_be_%0d", c),  32'(mem_byteenable), 32'(exp_be[c]));
            next();
        end
        drive_idle(); next();
        check("t031_ram20", ram[15'h20], 32'hA500_0011);
        check("t031_ram30", ram[15'h30], 32'h2222_0030);
        check("t031_ram21", ram[15'h21], 32'hA533_3321);
        check("t031_ram31", ram[15'h31], 32'h4444_4444);

        // Alternating single-master reads, one per cycle.
        for (int c = 0; c < 5; c++) begin
            drive_idle();
            if (c < 4) begin
                if (c % 2 == 0) begin m0_read = 1; m0_address = 15'h1; end
                else            begin m1_read = 1; m1_address = 15'h2; end
            end
            settle();
            if (c < 4)
                check($sformatf("t035_wr_%0d", c), 32'((c % 2 == 0) ? m0_waitrequest : m1_waitrequest), 32'd0);
            if (c > 0) begin
                check($sformatf("t035_rv0_%0d", c), 32'(m0_readdatavalid), 32'((c - 1) % 2 == 0));
                check($sformatf("t035_rv1_%0d", c), 32'(m1_readdatavalid), 32'((c - 1) % 2 == 1));
                if ((c - 1) % 2 == 0) check($sformatf("t035_rd0_%0d", c), m0_readdata, 32'hA500_0001);
                else                  check($sformatf("t035_rd1_%0d", c), m1_readdata, 32'hA500_0002);
            end
            next();
        end

        // Out-of-range write and read.
        m0_write = 1; m0_address = 15'd25600; m0_byteenable = 4'hF; m0_writedata = 32'h0BAD_0BAD;
        settle();
        check("t033_wr0", 32'(m0_waitrequest), 32'd0);
        check("t033_cs",  32'(mem_chipselect), 32'd0);
        check("t033_err0", 32'(range_err), 32'd0);
        next();
        drive_idle(); m0_read = 1; m0_address = 15'd25601;
        settle();
        check("t033_err1", 32'(range_err), 32'd1);
        check("t033_wr0r", 32'(m0_waitrequest), 32'd0);
        next(); drive_idle(); settle();
        check("t033_rv0", 32'(m0_readdatavalid), 32'd1);
        check("t033_rd0", m0_readdata, 32'h0);
        next(); settle();
        check("t033_rv0_off", 32'(m0_readdatavalid), 32'd0);
        check("t033_sticky", 32'(range_err), 32'd1);

        // Read and write together behaves as a write and flags an error.
        do_reset();
        m0_read = 1; m0_write = 1; m0_address = 15'h40; m0_byteenable = 4'hF; m0_writedata = 32'hDEAD_BEEF;
        settle();
        check("t020_we",  32'(mem_write), 32'd1);
        check("t020_cs",  32'(mem_chipselect), 32'd1);
        check("t020_err0", 32'(range_err), 32'd0);
        next(); drive_idle(); settle();
        check("t020_rv0", 32'(m0_readdatavalid), 32'd0);
        check("t020_err1", 32'(range_err), 32'd1);
        check("t020_ram", ram[15'h40], 32'hDEAD_BEEF);
        next();

        // Reset lands right behind a granted m1 read.
        m1_read = 1; m1_address = 15'h2;
        settle();
        check("t034_wr1", 32'(m1_waitrequest), 32'd0);
        #3 reset = 1'b1; m1_read = 0;
        #1;
        check_reset_values("t034");
        @(posedge clk); #1;
        check("t034_rv1_a", 32'(m1_readdatavalid), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        settle();
        check("t034_rv1_b", 32'(m1_readdatavalid), 32'd0);
        check("t034_err", 32'(range_err), 32'd0);
        next();
        check("t034_rv1_c", 32'(m1_readdatavalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
